matrix_store_writer: RTL and testbench



---
 rtl/matrix_store_writer_if.sv | 27 ++
 rtl/matrix_store_writer.sv | 154 +++++++++++++++
 tb/tb_matrix_store_writer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_store_writer_if.sv
// rtl/matrix_store_writer_if.sv - executor-to-store matrix write handshake bundle
interface matrix_store_writer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  write_request;
    logic                  write_ready;
    logic [2:0]            write_matrix_id;
    logic [7:0]            write_rows;
    logic [7:0]            write_cols;
    logic [7:0]            write_name [0:7];
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_data_valid;
    logic                  writer_ready;
    logic                  write_done;

    modport master (
        output write_request, write_matrix_id, write_rows, write_cols, write_name,
               write_data, write_data_valid,
        input  write_ready, writer_ready, write_done
    );

    modport slave (
        input  write_request, write_matrix_id, write_rows, write_cols, write_name,
               write_data, write_data_valid,
        output write_ready, writer_ready, write_done
    );
endinterface

// File: rtl/matrix_store_writer.sv
// rtl/matrix_store_writer.sv - packs header + row-major data into a BRAM slot per write transaction
// Optional data-stall timeout enabled by defining MATRIX_WRITER_TIMEOUT_EN.
module matrix_store_writer #(
    parameter int BLOCK_SIZE     = 1152,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_store_writer_if.slave  wr,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic                  error,
    output logic [7:0]            slot_valid
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR0 = 3'd1;
    localparam logic [2:0] S_HDR1 = 3'd2;
    localparam logic [2:0] S_HDR2 = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]            state;
    logic [2:0]            id_q;
    logic [7:0]            rows_q;
    logic [7:0]            cols_q;
    logic [63:0]           name_q;
    logic [15:0]           last_idx;
    logic [15:0]           elem_idx;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  write_done_q;

    logic [15:0]           req_count;
    logic                  req_bad;
    logic [ADDR_WIDTH-1:0] req_base;

    assign req_count = 16'(wr.write_rows) * 16'(wr.write_cols);
    assign req_bad   = (wr.write_rows == 8'd0) || (wr.write_cols == 8'd0) ||
                       (req_count > 16'(BLOCK_SIZE - 3));
    assign req_base  = ADDR_WIDTH'(wr.write_matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);

    assign wr.write_ready  = (state == S_IDLE);
    assign wr.writer_ready = (state == S_DATA);
    assign wr.write_done   = write_done_q;

`ifdef MATRIX_WRITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] idle_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            id_q         <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            name_q       <= '0;
            last_idx     <= '0;
            elem_idx     <= '0;
            wr_ptr       <= '0;
            write_done_q <= 1'b0;
            bram_wr_en   <= 1'b0;
            bram_wr_addr <= '0;
            bram_wr_data <= '0;
            error        <= 1'b0;
            slot_valid   <= '0;
`ifdef MATRIX_WRITER_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            bram_wr_en   <= 1'b0;
            write_done_q <= 1'b0;
            error        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr.write_request) begin
                        if (req_bad) begin
                            error <= 1'b1;
                        end else begin
                            id_q     <= wr.write_matrix_id;
                            rows_q   <= wr.write_rows;
                            cols_q   <= wr.write_cols;
                            name_q   <= {wr.write_name[0], wr.write_name[1], wr.write_name[2],
                                         wr.write_name[3], wr.write_name[4], wr.write_name[5],
                                         wr.write_name[6], wr.write_name[7]};
                            last_idx <= req_count - 16'd1;
                            elem_idx <= '0;
                            wr_ptr   <= req_base;
                            slot_valid[wr.write_matrix_id] <= 1'b0;
                            state    <= S_HDR0;
                        end
                    end
                end
                S_HDR0: begin
                    bram_wr_en   <= 1'b1;
                    bram_wr_addr <= wr_ptr;
                    bram_wr_data <= DATA_WIDTH'({16'h0, rows_q, cols_q});
                    wr_ptr       <= wr_ptr + 1'b1;
                    state        <= S_HDR1;
                end
                S_HDR1: begin
                    bram_wr_en   <= 1'b1;
                    bram_wr_addr <= wr_ptr;
                    bram_wr_data <= DATA_WIDTH'(name_q[63:32]);
                    wr_ptr       <= wr_ptr + 1'b1;
                    state        <= S_HDR2;
                end
                S_HDR2: begin
                    bram_wr_en   <= 1'b1;
                    bram_wr_addr <= wr_ptr;
                    bram_wr_data <= DATA_WIDTH'(name_q[31:0]);
                    wr_ptr       <= wr_ptr + 1'b1;
                    state        <= S_DATA;
`ifdef MATRIX_WRITER_TIMEOUT_EN
                    idle_cnt     <= '0;
`endif
                end
                S_DATA: begin
                    if (wr.write_data_valid) begin
                        bram_wr_en   <= 1'b1;
                        bram_wr_addr <= wr_ptr;
                        bram_wr_data <= wr.write_data;
                        wr_ptr       <= wr_ptr + 1'b1;
                        elem_idx     <= elem_idx + 16'd1;
`ifdef MATRIX_WRITER_TIMEOUT_EN
                        idle_cnt     <= '0;
`endif
                        // Completion is flagged with the last data write, not a cycle later.
                        if (elem_idx == last_idx) begin
                            write_done_q     <= 1'b1;
                            slot_valid[id_q] <= 1'b1;
                            state            <= S_DONE;
                        end
                    end
`ifdef MATRIX_WRITER_TIMEOUT_EN
                    else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        error <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_store_writer.sv
// tb/tb_matrix_store_writer.sv - table-driven scoreboard bench for matrix_store_writer
module tb_matrix_store_writer;
`ifdef MATRIX_WRITER_TIMEOUT_EN
    localparam int TB_TMO = 16;
`else
    localparam int TB_TMO = 65536;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bram_wr_en;
    logic [13:0] bram_wr_addr;
    logic [31:0] bram_wr_data;
    logic        error;
    logic [7:0]  slot_valid;

    matrix_store_writer_if #(.DATA_WIDTH(32)) mif ();

    matrix_store_writer #(
        .BLOCK_SIZE(1152), .DATA_WIDTH(32), .ADDR_WIDTH(14), .TIMEOUT_CYCLES(TB_TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr(mif.slave),
        .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
        .error(error), .slot_valid(slot_valid)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic [45:0] exp_q [$];
    logic [7:0]  sv_model = 8'h00;

    typedef struct {
        int          id;
        int          rows;
        int          cols;
        logic [63:0] nm;
        bit          err;
        int          mode;
        bit          extra;
        int          abort_after;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mif.write_done) done_cnt++;
        if (rst_n && bram_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {50'h0, bram_wr_addr}, 64'h3fff_ffff);
            end else begin
                logic [45:0] e;
                e = exp_q.pop_front();
                chk("bram_write", {18'h0, bram_wr_addr, bram_wr_data}, {18'h0, e});
            end
        end
    end

    task automatic do_txn(input vec_t v);
        int          base, cnt, k, cyc, first_rdy, guard, done0;
        logic [31:0] cur;
        logic [31:0] w0;
        bit          aborted;
        base = v.id * 1152;
        cnt  = v.rows * v.cols;
        guard = 0;
        @(negedge clk);
        while (!mif.write_ready && guard < 100) begin @(negedge clk); guard++; end
        chk("ready_before_req", {63'h0, mif.write_ready}, 64'h1);
        mif.write_request   = 1'b1;
        mif.write_matrix_id = 3'(v.id);
        mif.write_rows      = 8'(v.rows);
        mif.write_cols      = 8'(v.cols);
        for (int i = 0; i < 8; i++) mif.write_name[i] = v.nm[63-8*i -: 8];
        if (!v.err) begin
            w0 = {16'h0, 8'(v.rows), 8'(v.cols)};
            exp_q.push_back({14'(base),     w0});
            exp_q.push_back({14'(base + 1), v.nm[63:32]});
            exp_q.push_back({14'(base + 2), v.nm[31:0]});
            sv_model[v.id] = 1'b0;
        end
        done0 = done_cnt;
        @(negedge clk);
        mif.write_request = 1'b0;
        chk("error_T1", {63'h0, error}, {63'h0, v.err});
        chk("write_ready_T1", {63'h0, mif.write_ready}, {63'h0, v.err});
        chk("slot_valid_T1", {56'h0, slot_valid}, {56'h0, sv_model});
        if (v.err) begin
            @(negedge clk);
            chk("error_T2", {63'h0, error}, 64'h0);
            chk("no_writes_on_reject", 64'(exp_q.size()), 64'h0);
            return;
        end
        k = 0; cyc = 1; first_rdy = 0; guard = 0; aborted = 0;
        cur = (v.mode == 1) ? $urandom : 32'd1;
        while (k < cnt && guard < 10000) begin
            @(negedge clk);
            cyc++; guard++;
            if (mif.writer_ready && first_rdy == 0) first_rdy = cyc;
            if (v.abort_after >= 0 && k == v.abort_after) begin aborted = 1; break; end
            if (v.mode == 1 && cyc[0]) begin
                mif.write_data_valid = 1'b0;
            end else begin
                mif.write_data_valid = 1'b1;
                mif.write_data       = cur;
            end
            if (mif.write_data_valid && mif.writer_ready) begin
                exp_q.push_back({14'(base + 3 + k), cur});
                k++;
                cur = (v.mode == 1) ? $urandom : 32'(k + 1);
            end
        end
        chk("first_writer_ready_cycle", 64'(first_rdy), 64'd4);
        if (aborted) begin
            mif.write_data_valid = 1'b0;
`ifdef MATRIX_WRITER_TIMEOUT_EN
            if (v.mode == 2) begin
                guard = 0;
                while (!error && guard < 40) begin @(negedge clk); guard++; end
                chk("timeout_error", {63'h0, error}, 64'h1);
                chk("timeout_no_done", 64'(done_cnt - done0), 64'h0);
                @(negedge clk);
                chk("timeout_idle", {63'h0, mif.write_ready}, 64'h1);
                chk("timeout_slot_valid", {56'h0, slot_valid}, {56'h0, sv_model});
                chk("timeout_queue_empty", 64'(exp_q.size()), 64'h0);
                return;
            end
`endif
            rst_n = 1'b0;
            #1;
            chk("rst_write_ready", {63'h0, mif.write_ready}, 64'h1);
            chk("rst_writer_ready", {63'h0, mif.writer_ready}, 64'h0);
            chk("rst_bram", {17'h0, bram_wr_en, bram_wr_addr, bram_wr_data}, 64'h0);
            chk("rst_done_err", {62'h0, mif.write_done, error}, 64'h0);
            chk("rst_slot_valid", {56'h0, slot_valid}, 64'h0);
            exp_q.delete();
            sv_model = 8'h00;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        chk("data_accepted", 64'(k), 64'(cnt));
        @(negedge clk);
        if (!v.extra) mif.write_data_valid = 1'b0;
        sv_model[v.id] = 1'b1;
        chk("write_done_N1", {63'h0, mif.write_done}, 64'h1);
        chk("writer_ready_N1", {63'h0, mif.writer_ready}, 64'h0);
        chk("write_ready_N1", {63'h0, mif.write_ready}, 64'h0);
        chk("slot_valid_N1", {56'h0, slot_valid}, {56'h0, sv_model});
        @(negedge clk);
        mif.write_data_valid = 1'b0;
        chk("write_done_N2", {63'h0, mif.write_done}, 64'h0);
        chk("write_ready_N2", {63'h0, mif.write_ready}, 64'h1);
        chk("done_pulses", 64'(done_cnt - done0), 64'h1);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.write_request    = 1'b0;
        mif.write_matrix_id  = '0;
        mif.write_rows       = '0;
        mif.write_cols       = '0;
        mif.write_data       = '0;
        mif.write_data_valid = 1'b0;
        for (int i = 0; i < 8; i++) mif.write_name[i] = 8'h0;

        //           id rows cols name          err mode extra abort
        vecs[0] = '{2,  3,   4,  "MATRIX_A",    0,  0,   0,    -1};
        vecs[1] = '{5,  0,   4,  "ZERO_ROW",    1,  0,   0,    -1};
        vecs[2] = '{5,  34,  34, "TOO_BIG_",    1,  0,   0,    -1};
        vecs[3] = '{6,  5,   230,"JUST_OVR",    1,  0,   0,    -1};
        vecs[4] = '{1,  1,   1,  "ONE_ELEM",    0,  0,   0,    -1};
        vecs[5] = '{3,  28,  41, "MAX_FILL",    0,  1,   0,    -1};
        vecs[6] = '{7,  32,  32, "BIG_SEVN",    0,  1,   0,    -1};
        vecs[7] = '{6,  7,   0,  "ZERO_COL",    1,  0,   0,    -1};
        vecs[8] = '{2,  3,   4,  "REWRITE2",    0,  0,   1,    -1};

        repeat (3) @(negedge clk);
        chk("reset_write_ready", {63'h0, mif.write_ready}, 64'h1);
        chk("reset_outputs", {14'h0, mif.writer_ready, mif.write_done, error, bram_wr_en,
                              bram_wr_addr, bram_wr_data}, 64'h0);
        chk("reset_slot_valid", {56'h0, slot_valid}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i]);
            chk("slot_valid_after", {56'h0, slot_valid}, {56'h0, sv_model});
        end
        chk("slot_valid_final_table", {56'h0, slot_valid}, 64'h8e);

        // Reset after 5 of 12 elements, then a fresh transaction must succeed.
        do_txn('{4, 3, 4, "ABORTED_", 0, 0, 0, 5});
        chk("slot_valid_after_reset", {56'h0, slot_valid}, 64'h0);
        do_txn('{0, 2, 2, "AFTERRST", 0, 0, 0, -1});
        chk("slot_valid_after_recover", {56'h0, slot_valid}, 64'h01);

`ifdef MATRIX_WRITER_TIMEOUT_EN
        do_txn('{5, 2, 4, "STALLED_", 0, 2, 0, 3});
        chk("slot_valid_after_timeout", {56'h0, slot_valid}, 64'h01);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
